// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-in/parallel-out receiver.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int SIPO_WIDTH_DEF = 4;

  // Bit counter width: enough to hold 0..width-1.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry output register with valid/ready handoff and sticky overflow flag.
module sipo_out_buf
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             done,
  input  logic [WIDTH-1:0] word,
  input  logic             pout_rdy,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] pout,
  output logic             pout_vld,
  output logic             ovf
);

  // Handshake: a word is transferred on every rising edge where pout_vld and
  // pout_rdy are both 1; pout is held stable while pout_vld=1 and no transfer
  // happens. A new word may replace one being transferred on the same edge.
  logic take;
  logic load;
  logic drop;

  assign take = pout_vld & pout_rdy;
  assign load = done & (~pout_vld | take);
  assign drop = done & pout_vld & ~pout_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pout     <= '0;
      pout_vld <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (load) begin
        pout     <= word;
        pout_vld <= 1'b1;
      end else if (take) begin
        pout_vld <= 1'b0;
      end

      // A dropped word on the same edge as a clear must leave ovf set.
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver: MSB-first framing on sof, word handed to sipo_out_buf.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_vld,
  input  logic             sof,
  output logic [WIDTH-1:0] pout,
  output logic             pout_vld,
  input  logic             pout_rdy,
  output logic             busy,
  output logic             ovf,
  input  logic             clr_ovf
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word;
  logic             done;
  logic             shreg_msb_unused;

  // The completed word is the low WIDTH-1 history bits plus the bit on the wire.
  assign word             = {shreg[WIDTH-2:0], sin};
  assign done             = (state == SHIFT) & sin_vld & ~sof & (cnt == CNT_LAST);
  assign shreg_msb_unused = shreg[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sin_vld && sof) begin
            shreg <= {{(WIDTH-1){1'b0}}, sin};
            cnt   <= CNT_ONE;
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (sin_vld) begin
            if (sof) begin
              // Restart: the partial word is abandoned, sin is the new MSB.
              shreg <= {{(WIDTH-1){1'b0}}, sin};
              cnt   <= CNT_ONE;
            end else if (done) begin
              shreg <= word;
              cnt   <= '0;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              shreg <= word;
              cnt   <= cnt + CNT_ONE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  sipo_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .done    (done),
    .word    (word),
    .pout_rdy(pout_rdy),
    .clr_ovf (clr_ovf),
    .pout    (pout),
    .pout_vld(pout_vld),
    .ovf     (ovf)
  );

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx (WIDTH=4): frame table plus hand-written corner sequences.
module tb_sipo_rx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sin;
  logic         sin_vld;
  logic         sof;
  logic         pout_rdy;
  logic         clr_ovf;
  logic [W-1:0] pout;
  logic         pout_vld;
  logic         busy;
  logic         ovf;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_word;

  typedef struct {
    logic [W-1:0] word;
    bit           gapped;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  sipo_rx #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sin     (sin),
    .sin_vld (sin_vld),
    .sof     (sof),
    .pout    (pout),
    .pout_vld(pout_vld),
    .pout_rdy(pout_rdy),
    .busy    (busy),
    .ovf     (ovf),
    .clr_ovf (clr_ovf)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; returns 1 time unit after the edge that sampled them.
  task automatic step(input logic b, input logic s, input logic v);
    sin     = b;
    sof     = s;
    sin_vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit gapped, input bit push,
                           input bit clr_last);
    for (int i = W - 1; i >= 0; i--) begin
      if (gapped && i != W - 1) begin
        step(1'b1, 1'b0, 1'b0);
        check("gap_busy", {3'b0, busy}, 4'h1);
      end
      if (i == 0) begin
        if (push) exp_q.push_back(w);
        clr_ovf = clr_last;
      end
      step(w[i], (i == W - 1), 1'b1);
    end
    clr_ovf = 1'b0;
    sin_vld = 1'b0;
    sof     = 1'b0;
  endtask

  // Scoreboard: a transfer happens on the next rising edge when vld&rdy are seen here.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && pout_vld === 1'b1 && pout_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_unexpected: got %h, expected no transfer", pout);
      end else begin
        exp_word = exp_q.pop_front();
        check("scoreboard", pout, exp_word);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    sin      = 1'b0;
    sin_vld  = 1'b0;
    sof      = 1'b0;
    pout_rdy = 1'b1;
    clr_ovf  = 1'b0;

    vecs[0] = '{4'hB, 1'b0};
    vecs[1] = '{4'hC, 1'b1};
    vecs[2] = '{4'h0, 1'b0};
    vecs[3] = '{4'hF, 1'b1};
    for (int i = 4; i < 8; i++) begin
      vecs[i].word   = W'($urandom_range(0, 15));
      vecs[i].gapped = bit'($urandom_range(0, 1));
    end

    #12;
    check("rst_pout", pout, 4'h0);
    check("rst_vld", {3'b0, pout_vld}, 4'h0);
    check("rst_busy", {3'b0, busy}, 4'h0);
    check("rst_ovf", {3'b0, ovf}, 4'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Exact timing of 1,0,1,1 back to back: busy for 3 cycles, 1-cycle pulse.
    step(1'b1, 1'b1, 1'b1);
    check("t31_busy1", {3'b0, busy}, 4'h1);
    step(1'b0, 1'b0, 1'b1);
    check("t31_busy2", {3'b0, busy}, 4'h1);
    step(1'b1, 1'b0, 1'b1);
    check("t31_busy3", {3'b0, busy}, 4'h1);
    check("t31_vld_early", {3'b0, pout_vld}, 4'h0);
    exp_q.push_back(4'hB);
    step(1'b1, 1'b0, 1'b1);
    check("t31_busy4", {3'b0, busy}, 4'h0);
    check("t31_vld", {3'b0, pout_vld}, 4'h1);
    check("t31_pout", pout, 4'hB);
    step(1'b0, 1'b0, 1'b0);
    check("t31_vld_pulse", {3'b0, pout_vld}, 4'h0);
    idle(1);

    // Table frames, consumer always ready.
    for (int i = 0; i < 8; i++) begin
      send_word(vecs[i].word, vecs[i].gapped, 1'b1, 1'b0);
      check("tbl_vld", {3'b0, pout_vld}, 4'h1);
      check("tbl_pout", pout, vecs[i].word);
      check("tbl_busy", {3'b0, busy}, 4'h0);
      idle(1);
      check("tbl_vld_clr", {3'b0, pout_vld}, 4'h0);
    end

    // Overflow: held 4'hA is kept, 4'h5 dropped.
    pout_rdy = 1'b0;
    send_word(4'hA, 1'b0, 1'b1, 1'b0);
    idle(2);
    check("ovf_hold_pout", pout, 4'hA);
    check("ovf_none_yet", {3'b0, ovf}, 4'h0);
    send_word(4'h5, 1'b0, 1'b0, 1'b0);
    check("ovf_keep_pout", pout, 4'hA);
    check("ovf_set", {3'b0, ovf}, 4'h1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    check("ovf_clr", {3'b0, ovf}, 4'h0);
    check("ovf_vld_held", {3'b0, pout_vld}, 4'h1);
    pout_rdy = 1'b1;
    idle(1);
    check("ovf_drained", {3'b0, pout_vld}, 4'h0);

    // Set wins over a simultaneous clear.
    pout_rdy = 1'b0;
    send_word(4'h2, 1'b0, 1'b1, 1'b0);
    send_word(4'h4, 1'b1, 1'b0, 1'b1);
    check("ovf_set_wins", {3'b0, ovf}, 4'h1);
    check("ovf_sw_pout", pout, 4'h2);
    clr_ovf  = 1'b1;
    pout_rdy = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    check("ovf_sw_clr", {3'b0, ovf}, 4'h0);

    // Restart at cnt=WIDTH-1: 1,0,1 then a fresh frame 0,1,1,0.
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    send_word(4'h6, 1'b0, 1'b1, 1'b0);
    check("restart_pout", pout, 4'h6);
    check("restart_ovf", {3'b0, ovf}, 4'h0);
    idle(2);

    // Reset mid-frame with a held word; no decoding without a new sof.
    pout_rdy = 1'b0;
    send_word(4'h7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    sin_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", {3'b0, pout_vld}, 4'h0);
    check("mid_rst_pout", pout, 4'h0);
    check("mid_rst_busy", {3'b0, busy}, 4'h0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    pout_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'(($urandom_range(0, 1))), 1'b0, 1'b1);
      check("nosof_busy", {3'b0, busy}, 4'h0);
      check("nosof_vld", {3'b0, pout_vld}, 4'h0);
    end
    sin_vld = 1'b0;
    send_word(4'h9, 1'b0, 1'b1, 1'b0);
    check("post_rst_pout", pout, 4'h9);
    idle(2);

    // Completion coinciding with a transfer: 4'h3 leaves as 4'h9 loads.
    pout_rdy = 1'b0;
    send_word(4'h3, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    exp_q.push_back(4'h9);
    pout_rdy = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    sin_vld = 1'b0;
    check("coinc_vld", {3'b0, pout_vld}, 4'h1);
    check("coinc_pout", pout, 4'h9);
    check("coinc_ovf", {3'b0, ovf}, 4'h0);
    idle(3);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d words pending, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
